// File: rtl/wide_add_seq.sv
// Multi-word add/subtract sequencer: one 32-bit carry-lookahead adder is
// reused once per word, lowest word first, with the inter-word carry held in
// a register. Valid/ready handshakes on both the operand and result sides.

module wide_add_seq #(
  parameter int unsigned WORDS = 4  // 32-bit words per operand, 2..8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*WORDS-1:0]   a,
  input  logic [32*WORDS-1:0]   b,
  input  logic                  cin,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*WORDS-1:0]   sum,
  output logic                  carry,
  output logic                  overflow,
  output logic                  busy
);

  localparam int unsigned Width   = 32 * WORDS;
  localparam logic [2:0]  IdxLast = 3'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q;
  logic [Width-1:0]   a_q;
  logic [Width-1:0]   b_q;
  logic [Width-1:0]   sum_q;
  logic               c_q;
  logic [2:0]         idx_q;
  logic               carry_q;
  logic               ovf_q;

  logic [31:0]        add_sum;
  logic               add_cout;
  logic               add_c31;

  adder32 u_adder32 (
    .a_i    (a_q[31:0]),
    .b_i    (b_q[31:0]),
    .cin_i  (c_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // Carry into the sign bit, recovered from the sum bit and its operands.
  assign add_c31 = a_q[31] ^ b_q[31] ^ add_sum[31];

  // Sequencer: accept in IDLE, one word per cycle in RUN, hold result in DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      idx_q   <= 3'd0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            c_q     <= sub ? 1'b1 : cin;
            idx_q   <= 3'd0;
            state_q <= StRun;
          end
        end
        StRun: begin
          sum_q <= {add_sum, sum_q[Width-1:32]};
          a_q   <= {32'h0, a_q[Width-1:32]};
          b_q   <= {32'h0, b_q[Width-1:32]};
          c_q   <= add_cout;
          if (idx_q == IdxLast) begin
            // idx is parked at zero so it never exceeds WORDS-1.
            idx_q   <= 3'd0;
            carry_q <= add_cout;
            ovf_q   <= add_c31 ^ add_cout;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;

endmodule

// 32-bit adder: 4-bit lookahead groups, group carries chained.
module adder32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;
  logic [8:0]  gc;

  // Bit generate/propagate, group lookahead, then per-bit carries.
  always_comb begin
    g  = a_i & b_i;
    p  = a_i ^ b_i;
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int k = 0; k < 8; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = cin_i;
    for (int k = 0; k < 8; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    for (int k = 0; k < 8; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    sum_o  = p ^ c;
    cout_o = gc[8];
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// Scoreboard bench for wide_add_seq with WORDS=4: stimulus pushes expected
// results, a negedge monitor pops and compares on each result handshake.

module tb_wide_add_seq;

  localparam int unsigned Words = 4;
  localparam int unsigned W     = 32 * Words;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry;
  logic         overflow;
  logic         busy;

  wide_add_seq #(.WORDS(Words)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .overflow  (overflow),
    .busy      (busy)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic prev_ov = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Monitor: latency on out_valid rise, scoreboard compare on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) begin
          fail_now("stray out_valid");
        end else begin
          int acc;
          acc = acc_q.pop_front();
          check("latency", W'(cyc - acc), W'(Words));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected result");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sum", sum, e.s);
          check("carry", W'(carry), W'(e.c));
          check("overflow", W'(overflow), W'(e.o));
        end
      end
      if (in_valid && in_ready) acc_q.push_back(cyc + 1);
      prev_ov = out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  // Drive one operation and return its accept edge number; in_valid is left high.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                       input logic isub, output int edge_no);
    a        = ia;
    b        = ib;
    cin      = icin;
    sub      = isub;
    in_valid = 1'b1;
    edge_no  = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        edge_no = cyc + 1;
        break;
      end
    end
    if (edge_no < 0) fail_now("accept");
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input logic [W-1:0] s, input logic c, input logic o);
    exp_t e;
    e.s = s;
    e.c = c;
    e.o = o;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      fail_now("drain");
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e0;
    int e1;
    int e2;
    logic [W-1:0] ones;
    ones      = '1;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst in_ready", W'(in_ready), W'(1));
    check("rst out_valid", W'(out_valid), W'(0));
    check("rst busy", W'(busy), W'(0));
    check("rst sum", sum, '0);
    check("rst carry/ovf", W'({carry, overflow}), W'(0));
    @(posedge clk);
    #1;

    // Carry ripples through every word.
    expect_res('0, 1'b1, 1'b0);
    issue(ones, W'(1), 1'b0, 1'b0, e0);
    in_valid = 1'b0;
    drain();

    // 0 - 1 with cin ignored.
    expect_res(ones, 1'b0, 1'b0);
    issue('0, W'(1), 1'b1, 1'b1, e0);
    in_valid = 1'b0;
    drain();

    // Signed overflow, both directions.
    expect_res(128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1);
    issue(128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, W'(1), 1'b0, 1'b0, e0);
    in_valid = 1'b0;
    drain();
    expect_res(128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    issue(128'h8000_0000_0000_0000_0000_0000_0000_0000, W'(1), 1'b0, 1'b1, e0);
    in_valid = 1'b0;
    drain();

    // Backpressure: result held, new requests ignored.
    out_ready = 1'b0;
    expect_res(128'h1_0000_0000, 1'b0, 1'b0);
    issue(128'hFFFF_FFFF, W'(1), 1'b0, 1'b0, e0);
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("bp out_valid", W'(out_valid), W'(1));
      check("bp sum", sum, 128'h1_0000_0000);
      check("bp in_ready", W'(in_ready), W'(0));
      @(posedge clk);
      #1;
      in_valid = ~in_valid;
      a        = W'(i * 17 + 3);
      b        = W'(i + 100);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp in_ready after", W'(in_ready), W'(1));
    check("bp out_valid after", W'(out_valid), W'(0));
    drain();

    // Reset while idx==2 discards the operation.
    issue(128'h1234, 128'h5678, 1'b0, 1'b0, e0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    acc_q.delete();
    @(negedge clk);
    check("mid-rst in_ready", W'(in_ready), W'(1));
    check("mid-rst out_valid", W'(out_valid), W'(0));
    check("mid-rst busy", W'(busy), W'(0));
    check("mid-rst sum", sum, '0);
    repeat (6) @(posedge clk);
    #1;
    expect_res(W'(12), 1'b0, 1'b0);
    issue(W'(5), W'(7), 1'b0, 1'b0, e0);
    in_valid = 1'b0;
    drain();

    // Back-to-back with in_valid and out_ready held high.
    expect_res(W'(3), 1'b0, 1'b0);
    expect_res(W'(7), 1'b0, 1'b0);
    expect_res(128'h2_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0);
    issue(W'(1), W'(2), 1'b0, 1'b0, e0);
    issue(W'(3), W'(4), 1'b0, 1'b0, e1);
    issue(128'h1_0000_0000_0000_0000_0000_0000, 128'h1_0000_0000_0000_0000_0000_0000,
          1'b0, 1'b0, e2);
    in_valid = 1'b0;
    check("b2b spacing 1", W'(e1 - e0), W'(6));
    check("b2b spacing 2", W'(e2 - e1), W'(6));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
